// File: rtl/sense_debounce.sv
// Synchronises and debounces one raw board input; reports level, edge strobes and a saturating rise count.
// Optional LED activity stretcher is built only when SENSE_STRETCH_EN is defined.
module sense_debounce #(
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int CNT_W           = 16,
  parameter int STRETCH_CYCLES  = 4800000
) (
  input  logic             i_ifclk,
  input  logic             i_rst_n,
  input  logic             i_sense,
  input  logic             i_clr,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat,
  output logic             o_activity
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

  logic            s1;
  logic            s;
  logic [DB_W-1:0] db_cnt;
  logic            accept;

  // The input has disagreed with the accepted level for a full qualification window.
  assign accept = (s != o_level) && (db_cnt == DB_LAST);

  always_ff @(posedge i_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= i_sense;
      s  <= s1;
    end
  end

  always_ff @(posedge i_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_cnt  <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      o_rise <= accept && s;
      o_fall <= accept && !s;
      if (s == o_level) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt  <= '0;
        o_level <= s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A clear coinciding with a rise strobe keeps that rise, so the count restarts at one.
  always_ff @(posedge i_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
      o_sat   <= 1'b0;
    end else if (i_clr) begin
      o_count <= o_rise ? CNT_W'(1) : '0;
      o_sat   <= 1'b0;
    end else if (o_rise && (o_count != CNT_MAX)) begin
      o_count <= o_count + 1'b1;
      o_sat   <= (o_count == CNT_PRE);
    end
  end

`ifdef SENSE_STRETCH_EN
  localparam int              ST_W      = $clog2(STRETCH_CYCLES + 1);
  localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(STRETCH_CYCLES - 1);

  logic [ST_W-1:0] st_cnt;

  // Each accepted edge reloads the window, so closely spaced edges merge into one long pulse.
  always_ff @(posedge i_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_cnt     <= '0;
      o_activity <= 1'b0;
    end else if (accept) begin
      st_cnt     <= ST_RELOAD;
      o_activity <= 1'b1;
    end else if (st_cnt != '0) begin
      st_cnt <= st_cnt - 1'b1;
    end else begin
      o_activity <= 1'b0;
    end
  end
`else
  assign o_activity = 1'b0;
`endif

endmodule
